rc4_ksa_param: RTL and testbench

- Parametrised RC4 key-scheduling engine.
- Sequence: fills an external single-port S memory with the identity permutation, then runs the KSA swap loop using a latched secret key.
- Generalises the fixed 3-byte, 256-entry scheduler in three ways: key length, S depth and memory read latency are all parameters.
- Adds start/busy/done handshake and restartability.
- Sits between the key-search controller, which drives start/secret_key, and the S RAM. The PRGA/decrypt stage consumes S after done.

---
 rtl/rc4_pkg.sv | 36 +++
 rtl/rc4_wait_ctr.sv | 37 +++
 rtl/rc4_ksa_param.sv | 197 +++++++++++++++++++
 tb/tb_rc4_ksa_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg
//   Shared definitions for the RC4 key-scheduling engine and its helpers.
//   - rc4_state_t : FSM state encoding for the KSA controller
//   - N           : full S depth for 8-bit S entries; narrower S scales down from it
//   - key_byte()  : picks byte k of a packed key whose byte 0 sits in the MSBs
package rc4_pkg;

    localparam int KEY_MAX_BYTES = 16;
    localparam int KEY_MAX_BITS  = 8 * KEY_MAX_BYTES;
    localparam int N             = 256;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        READ_I,
        WAIT_I,
        READ_J,
        WAIT_J,
        WRITE_I,
        WRITE_J,
        COMMIT,
        DONE
    } rc4_state_t;

    // The key is passed zero-extended to the widest supported key so a
    // single function serves every KEY_BYTES setting. Byte 0 is the most
    // significant byte of the key_bytes-wide value.
    function automatic logic [7:0] key_byte(
        input logic [KEY_MAX_BITS-1:0] key,
        input int                      key_bytes,
        input int                      kidx
    );
        return 8'(key >> (8 * (key_bytes - 1 - kidx)));
    endfunction

endpackage

// File: rtl/rc4_wait_ctr.sv
// rc4_wait_ctr
//   Down-counter that stretches a wait state to cover the S memory read
//   latency. Load it on the cycle the read address is issued; 'expired'
//   is then high during the LAT-th cycle spent waiting.
//   Ports:
//     CLOCK_50 in  system clock
//     reset_n  in  synchronous active-low reset
//     load     in  restart the wait (one pulse per read)
//     expired  out wait has lasted LAT cycles, move on
module rc4_wait_ctr #(
    parameter int LAT = 1
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic load,
    output logic expired
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [CW-1:0] count;

    // Loading LAT-1 means a latency of one gives a single wait cycle and
    // each extra cycle of latency adds one more.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(LAT - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/rc4_ksa_param.sv
// rc4_ksa_param
//   Parametrised RC4 key-scheduling engine. On start it latches the key,
//   writes the identity permutation into an external single-port S RAM,
//   then runs the KSA swap loop against that RAM and raises done.
//   Ports:
//     CLOCK_50   in  system clock
//     reset_n    in  synchronous active-low reset
//     start      in  begin a schedule (only looked at in IDLE/DONE)
//     secret_key in  8*KEY_BYTES key, byte 0 in the MSBs
//     busy       out schedule in progress
//     done       out schedule complete, held until the next start
//     mem_addr   out S address
//     mem_wdata  out S write data
//     mem_wren   out S write enable
//     mem_rdata  in  S read data, MEM_LAT cycles after the address
module rc4_ksa_param
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [ADDR_W-1:0]      mem_wdata,
    output logic                   mem_wren,
    input  logic [ADDR_W-1:0]      mem_rdata
);

    localparam int             DEPTH     = N >> (8 - ADDR_W);
    localparam int             CW        = ADDR_W + 1;
    localparam logic [ADDR_W:0] I_LAST    = CW'(DEPTH - 1);
    localparam logic [ADDR_W:0] KIDX_LAST = CW'(KEY_BYTES - 1);

    rc4_state_t state_q, state_d;

    // i and kidx carry one spare bit so the end of a pass is visible; j is
    // always reduced mod DEPTH, so it only needs ADDR_W bits.
    logic [ADDR_W:0]        i_q, i_d;
    logic [ADDR_W:0]        kidx_q, kidx_d;
    logic [ADDR_W-1:0]      j_q, j_d;
    logic [ADDR_W-1:0]      si_q, si_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;

    logic                   busy_d, done_d, wren_d;
    logic [ADDR_W-1:0]      addr_d, wdata_d;
    logic [ADDR_W-1:0]      j_sum;

    logic                   wait_load, wait_expired;

    // Both read states are always followed by a wait state, so the
    // latency counter is armed whenever a read address is issued.
    assign wait_load = (state_q == READ_I) || (state_q == READ_J);

    rc4_wait_ctr #(
        .LAT(MEM_LAT)
    ) u_wait_ctr (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .load     (wait_load),
        .expired  (wait_expired)
    );

    // Next-state and next-output logic. Every output is registered, so a
    // bus access decided here appears on the pins in the following cycle.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        si_d    = si_q;
        key_d   = key_q;
        busy_d  = busy;
        done_d  = done;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wren_d  = 1'b0;

        // Key bytes are cut to ADDR_W bits; the sum wraps naturally mod DEPTH.
        j_sum = j_q + mem_rdata
              + ADDR_W'(key_byte(KEY_MAX_BITS'(key_q), KEY_BYTES, int'(kidx_q)));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    key_d   = secret_key;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = FILL;
                end
            end

            FILL: begin
                wren_d  = 1'b1;
                addr_d  = i_q[ADDR_W-1:0];
                wdata_d = i_q[ADDR_W-1:0];
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = READ_I;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end

            READ_I: begin
                addr_d  = i_q[ADDR_W-1:0];
                state_d = WAIT_I;
            end

            WAIT_I: begin
                if (wait_expired) begin
                    state_d = READ_J;
                end
            end

            READ_J: begin
                si_d    = mem_rdata;
                j_d     = j_sum;
                addr_d  = j_sum;
                state_d = WAIT_J;
            end

            WAIT_J: begin
                if (wait_expired) begin
                    state_d = WRITE_I;
                end
            end

            WRITE_I: begin
                wren_d  = 1'b1;
                addr_d  = i_q[ADDR_W-1:0];
                wdata_d = mem_rdata;
                state_d = WRITE_J;
            end

            // When i==j both writes hit the same word with the same value,
            // so the swap needs no special case.
            WRITE_J: begin
                wren_d  = 1'b1;
                addr_d  = j_q;
                wdata_d = si_q;
                i_d     = i_q + 1'b1;
                kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                state_d = (i_q == I_LAST) ? COMMIT : READ_I;
            end

            // Lets the RAM capture the last swap write before done is seen.
            COMMIT: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any schedule in flight.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            kidx_q    <= '0;
            si_q      <= '0;
            key_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            kidx_q    <= kidx_d;
            si_q      <= si_d;
            key_q     <= key_d;
            busy      <= busy_d;
            done      <= done_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wren  <= wren_d;
        end
    end

endmodule

// File: tb/tb_rc4_ksa_param.sv
// tb_rc4_ksa_param
//   Three engines share clock and reset: dut0 (defaults), dut1 (1-byte key,
//   16-entry S) and dut2 (2-cycle RAM latency), each with its own RAM model.
//   The stimulus pushes the expected done cycle and final S for every run
//   into a scoreboard; a monitor pops and checks whenever done rises.
module tb_rc4_ksa_param;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic reset_n;
    int   cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;
    int sb[$];

    // dut0: KEY_BYTES=3, ADDR_W=8, MEM_LAT=1
    logic        start0, busy0, done0, wren0;
    logic [23:0] key0;
    logic [7:0]  addr0, wdata0, rdata0;
    logic [7:0]  ram0 [256];

    // dut1: KEY_BYTES=1, ADDR_W=4, MEM_LAT=1
    logic        start1, busy1, done1, wren1;
    logic [7:0]  key1;
    logic [3:0]  addr1, wdata1, rdata1;
    logic [3:0]  ram1 [16];

    // dut2: KEY_BYTES=3, ADDR_W=8, MEM_LAT=2
    logic        start2, busy2, done2, wren2;
    logic [23:0] key2;
    logic [7:0]  addr2, wdata2, rdata2, pipe2;
    logic [7:0]  ram2 [256];

    rc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(8), .MEM_LAT(1)) dut0 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start0), .secret_key(key0),
        .busy(busy0), .done(done0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_wren(wren0), .mem_rdata(rdata0));

    rc4_ksa_param #(.KEY_BYTES(1), .ADDR_W(4), .MEM_LAT(1)) dut1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start1), .secret_key(key1),
        .busy(busy1), .done(done1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_wren(wren1), .mem_rdata(rdata1));

    rc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(8), .MEM_LAT(2)) dut2 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start2), .secret_key(key2),
        .busy(busy2), .done(done2), .mem_addr(addr2), .mem_wdata(wdata2),
        .mem_wren(wren2), .mem_rdata(rdata2));

    // Synchronous RAM models: one-cycle read for dut0/dut1, two-cycle for dut2.
    always @(posedge CLOCK_50) begin
        if (wren0) ram0[addr0] <= wdata0;
        rdata0 <= ram0[addr0];
        if (wren1) ram1[addr1] <= wdata1;
        rdata1 <= ram1[addr1];
        if (wren2) ram2[addr2] <= wdata2;
        pipe2  <= ram2[addr2];
        rdata2 <= pipe2;
    end

    function automatic int kb_of(input int d);
        return (d == 1) ? 1 : 3;
    endfunction

    function automatic int aw_of(input int d);
        return (d == 1) ? 4 : 8;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_wren(input int d);
        case (d)
            0:       return wren0;
            1:       return wren1;
            default: return wren2;
        endcase
    endfunction

    function automatic logic [31:0] get_addr(input int d);
        case (d)
            0:       return 32'(addr0);
            1:       return 32'(addr1);
            default: return 32'(addr2);
        endcase
    endfunction

    function automatic logic [31:0] get_wdata(input int d);
        case (d)
            0:       return 32'(wdata0);
            1:       return 32'(wdata1);
            default: return 32'(wdata2);
        endcase
    endfunction

    function automatic logic [31:0] ram_val(input int d, input int k);
        case (d)
            0:       return 32'(ram0[k]);
            1:       return 32'(ram1[k]);
            default: return 32'(ram2[k]);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input int d, input logic st, input logic [23:0] key);
        case (d)
            0:       begin start0 = st; key0 = key;      end
            1:       begin start1 = st; key1 = key[7:0]; end
            default: begin start2 = st; key2 = key;      end
        endcase
    endtask

    // Textbook RC4 KSA over an n-entry S: j = (j + S[i] + K[i mod kb]) mod n.
    task automatic push_expected(input int d, input logic [23:0] key, input int done_cycle);
        int s[256];
        int n, kb, j, kbyte, tmp;
        n  = 1 << aw_of(d);
        kb = kb_of(d);
        j  = 0;
        for (int k = 0; k < n; k++) s[k] = k;
        for (int i = 0; i < n; i++) begin
            kbyte = int'((key >> (8 * (kb - 1 - (i % kb)))) & 24'hFF);
            j     = (j + s[i] + kbyte) % n;
            tmp   = s[i];
            s[i]  = s[j];
            s[j]  = tmp;
        end
        sb.push_back(d);
        sb.push_back(done_cycle);
        for (int k = 0; k < n; k++) sb.push_back(s[k]);
    endtask

    // Issues one start pulse, then follows the identity fill cycle by cycle.
    task automatic applyStimulus(input int d, input logic [23:0] key_in,
                                 input bit expect_result, output int t0);
        logic [23:0] key;
        int n;
        key = (d == 1) ? (key_in & 24'hFF) : key_in;
        n   = 1 << aw_of(d);
        @(negedge CLOCK_50);
        drive(d, 1'b1, key);
        t0 = cyc + 1;
        if (expect_result)
            push_expected(d, key, t0 + n * (5 + 2 * lat_of(d)) + 1);
        @(negedge CLOCK_50);
        drive(d, 1'b0, 24'($urandom));
        checkOutput("accept_busy", 32'(get_busy(d)), 32'd1);
        checkOutput("accept_done_low", 32'(get_done(d)), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge CLOCK_50);
            checkOutput("fill_wren", 32'(get_wren(d)), 32'd1);
            checkOutput("fill_addr", get_addr(d), 32'(k));
            checkOutput("fill_wdata", get_wdata(d), 32'(k));
        end
        @(negedge CLOCK_50);
        checkOutput("fill_end_wren", 32'(get_wren(d)), 32'd0);
    endtask

    task automatic wait_done(input int d);
        int budget;
        int waited;
        budget = (1 << aw_of(d)) * (5 + 2 * lat_of(d)) + 64;
        waited = 0;
        while (get_done(d) !== 1'b1 && waited < budget) begin
            checkOutput("busy_while_running", 32'(get_busy(d)), 32'd1);
            @(negedge CLOCK_50);
            waited++;
        end
        if (get_done(d) !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_timeout: dut%0d done still low after %0d cycles, required within %0d",
                     d, waited, budget);
        end
    endtask

    task automatic score_run(input int d);
        int id, exp_cyc, n;
        if (sb.size() < 2) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_done: dut%0d raised done at cycle %0d, no run expected", d, cyc);
            return;
        end
        id      = sb.pop_front();
        exp_cyc = sb.pop_front();
        checkOutput("done_dut", 32'(d), 32'(id));
        checkOutput("done_cycle", 32'(cyc), 32'(exp_cyc));
        checkOutput("busy_at_done", 32'(get_busy(d)), 32'd0);
        n = 1 << aw_of(id);
        for (int k = 0; k < n && sb.size() > 0; k++)
            checkOutput("s_final", ram_val(d, k), 32'(sb.pop_front()));
    endtask

    // Monitor: every rising edge of a done output retires one scoreboard entry.
    logic [2:0] done_vec;
    logic [2:0] prev_done = 3'b000;
    assign done_vec = {done2, done1, done0};

    always @(negedge CLOCK_50) begin
        for (int d = 0; d < 3; d++)
            if (done_vec[d] === 1'b1 && prev_done[d] !== 1'b1) score_run(d);
        prev_done <= done_vec;
    end

    initial begin
        int t0;
        int lows;

        // Reset held three cycles with start asserted everywhere.
        reset_n = 1'b0;
        start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
        key0 = '0; key1 = '0; key2 = '0;
        repeat (3) begin
            @(negedge CLOCK_50);
            checkOutput("reset_busy", 32'(busy0), 32'd0);
            checkOutput("reset_done", 32'(done0), 32'd0);
            checkOutput("reset_wren", 32'(wren0), 32'd0);
            checkOutput("reset_addr", 32'(addr0), 32'd0);
            checkOutput("reset_wdata", 32'(wdata0), 32'd0);
            checkOutput("reset_busy1", 32'(busy1), 32'd0);
            checkOutput("reset_wren2", 32'(wren2), 32'd0);
        end
        reset_n = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("idle_busy", 32'(busy0), 32'd0);
        checkOutput("idle_wren", 32'(wren0), 32'd0);

        // Reference key, then two back-to-back runs started from DONE.
        applyStimulus(0, 24'h000249, 1'b1, t0);
        wait_done(0);
        applyStimulus(0, 24'h000001, 1'b1, t0);
        wait_done(0);
        applyStimulus(0, 24'h000002, 1'b1, t0);
        wait_done(0);

        // Start while busy is ignored; a one-cycle reset then aborts the run.
        applyStimulus(0, 24'($urandom), 1'b0, t0);
        while (cyc < t0 + 500) @(negedge CLOCK_50);
        start0 = 1'b1;
        key0   = 24'($urandom);
        @(negedge CLOCK_50);
        start0 = 1'b0;
        checkOutput("ignored_start_busy", 32'(busy0), 32'd1);
        checkOutput("ignored_start_done", 32'(done0), 32'd0);
        lows = 0;
        repeat (7) begin
            @(negedge CLOCK_50);
            if (wren0 !== 1'b1) lows++;
        end
        checkOutput("ignored_start_no_refill", 32'(lows > 0), 32'd1);
        while (cyc < t0 + 900) @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        checkOutput("abort_done", 32'(done0), 32'd0);
        checkOutput("abort_wren", 32'(wren0), 32'd0);
        checkOutput("abort_addr", 32'(addr0), 32'd0);
        checkOutput("abort_wdata", 32'(wdata0), 32'd0);
        @(negedge CLOCK_50);
        checkOutput("abort_stays_idle", 32'(wren0), 32'd0);
        applyStimulus(0, 24'($urandom), 1'b1, t0);
        wait_done(0);

        // Small S with a single key byte.
        applyStimulus(1, 24'h00000F, 1'b1, t0);
        wait_done(1);
        repeat (2) begin
            applyStimulus(1, 24'($urandom), 1'b1, t0);
            wait_done(1);
        end

        // Two-cycle RAM latency.
        applyStimulus(2, 24'hFFFFFF, 1'b1, t0);
        wait_done(2);
        applyStimulus(2, 24'($urandom), 1'b1, t0);
        wait_done(2);

        applyStimulus(0, 24'($urandom), 1'b1, t0);
        wait_done(0);

        @(negedge CLOCK_50);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
